tfd_multi: RTL and testbench

Multi-channel programmable timer/frequency divider, the parametrised successor to the single-channel TFD. Each of CH independent channels counts down a programmable period and emits a one-cycle period pulse (yp) and a duty-programmable level output (yl). Each channel runs in periodic or one-shot mode. Configuration goes through a shared write port into per-channel shadow registers that take effect at the next period load, so running channels reconfigure glitch-free.

---
 rtl/tfd_multi.sv | 146 ++++++++++++++
 tb/tb_tfd_multi.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/tfd_multi.sv
// Multi-channel programmable timer / frequency divider.
// Each channel counts down a shadowed period and drives a period pulse, a duty level and a one-shot done pulse.

module tfd_chan #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wr,
    input  logic [WIDTH-1:0] k_in,
    input  logic [WIDTH-1:0] h_in,
    input  logic             mode_in,
    input  logic             st,
    output logic [WIDTH-1:0] q,
    output logic             yp,
    output logic             yl,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] k_sh, h_sh, k_act, h_act;
    logic             mode_sh, mode_act, st_d;
    logic [WIDTH-1:0] k_eff, h_eff;
    logic             mode_eff, start;
    logic [WIDTH:0]   thr;

    // A write landing on the same edge as a load is seen by that load.
    assign k_eff    = wr ? k_in    : k_sh;
    assign h_eff    = wr ? h_in    : h_sh;
    assign mode_eff = wr ? mode_in : mode_sh;
    assign start    = st & ~st_d;

    // Borrow out of k-h means h exceeds k: level stays high for the whole period.
    assign thr  = {1'b0, k_act} - {1'b0, h_act};
    assign busy = (state == RUN);
    assign yl   = busy & (thr[WIDTH] | ({1'b0, q} > thr));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            k_sh     <= '0;
            h_sh     <= '0;
            mode_sh  <= 1'b0;
            k_act    <= '0;
            h_act    <= '0;
            mode_act <= 1'b0;
            st_d     <= 1'b0;
            q        <= '0;
            yp       <= 1'b0;
            done     <= 1'b0;
        end else begin
            st_d <= st;
            done <= 1'b0;
            if (wr) begin
                k_sh    <= k_in;
                h_sh    <= h_in;
                mode_sh <= mode_in;
            end
            case (state)
                IDLE, DONE: begin
                    if (start && k_eff != '0) begin
                        k_act    <= k_eff;
                        h_act    <= h_eff;
                        mode_act <= mode_eff;
                        q        <= k_eff;
                        yp       <= 1'b1;
                        state    <= RUN;
                    end else begin
                        q  <= '0;
                        yp <= 1'b0;
                    end
                end
                RUN: begin
                    if (!st) begin
                        state <= IDLE;
                        q     <= '0;
                        yp    <= 1'b0;
                    end else if (q > WIDTH'(1)) begin
                        q  <= q - WIDTH'(1);
                        yp <= 1'b0;
                    end else if (mode_act) begin
                        state <= DONE;
                        q     <= '0;
                        yp    <= 1'b0;
                        done  <= 1'b1;
                    end else if (k_eff != '0) begin
                        k_act    <= k_eff;
                        h_act    <= h_eff;
                        mode_act <= mode_eff;
                        q        <= k_eff;
                        yp       <= 1'b1;
                    end else begin
                        state <= IDLE;
                        q     <= '0;
                        yp    <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    q     <= '0;
                    yp    <= 1'b0;
                end
            endcase
        end
    end
endmodule

module tfd_multi #(
    parameter int WIDTH = 32,
    parameter int CH    = 4,
    parameter int CHW   = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                we,
    input  logic [CHW-1:0]      wsel,
    input  logic [WIDTH-1:0]    k_in,
    input  logic [WIDTH-1:0]    h_in,
    input  logic                mode_in,
    input  logic [CH-1:0]       st,
    output logic [CH*WIDTH-1:0] q,
    output logic [CH-1:0]       yp,
    output logic [CH-1:0]       yl,
    output logic [CH-1:0]       busy,
    output logic [CH-1:0]       done
);
    // Out-of-range selects never match any channel index, so they are dropped.
    for (genvar i = 0; i < CH; i++) begin : g_ch
        tfd_chan #(.WIDTH(WIDTH)) u_ch (
            .clk     (clk),
            .rstn    (rstn),
            .wr      (we && (wsel == CHW'(i))),
            .k_in    (k_in),
            .h_in    (h_in),
            .mode_in (mode_in),
            .st      (st[i]),
            .q       (q[i*WIDTH +: WIDTH]),
            .yp      (yp[i]),
            .yl      (yl[i]),
            .busy    (busy[i]),
            .done    (done[i])
        );
    end
endmodule

// File: tb/tb_tfd_multi.sv
// Bench for tfd_multi: directed test-plan steps then random traffic, all checked against a cycle model.
module tb_tfd_multi;
    localparam int W = 32, CH = 4, CHW = 2;

    logic            clk = 1'b0, rstn = 1'b0, we = 1'b0, mode_in = 1'b0;
    logic [CHW-1:0]  wsel = '0;
    logic [W-1:0]    k_in = '0, h_in = '0;
    logic [CH-1:0]   st = '0;
    logic [CH*W-1:0] q;
    logic [CH-1:0]   yp, yl, busy, done;

    tfd_multi #(.WIDTH(W), .CH(CH)) dut (
        .clk(clk), .rstn(rstn), .we(we), .wsel(wsel), .k_in(k_in), .h_in(h_in),
        .mode_in(mode_in), .st(st), .q(q), .yp(yp), .yl(yl), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int vecs = 0, errs = 0;

    // Model: a channel is either running with 'left' cycles remaining in the period, or not.
    bit          m_run[CH], m_mode[CH], m_msh[CH], m_stp[CH], m_yp[CH], m_done[CH];
    int unsigned m_left[CH], m_k[CH], m_h[CH], m_ksh[CH], m_hsh[CH];

    function automatic void m_reset();
        for (int c = 0; c < CH; c++) begin
            m_run[c] = 0; m_mode[c] = 0; m_msh[c] = 0; m_stp[c] = 0; m_yp[c] = 0; m_done[c] = 0;
            m_left[c] = 0; m_k[c] = 0; m_h[c] = 0; m_ksh[c] = 0; m_hsh[c] = 0;
        end
    endfunction

    function automatic void m_load(int c, int unsigned k, int unsigned h, bit md);
        m_run[c] = 1; m_k[c] = k; m_h[c] = h; m_mode[c] = md; m_left[c] = k; m_yp[c] = 1;
    endfunction

    function automatic void m_step();
        for (int c = 0; c < CH; c++) begin
            bit          wr, md;
            int unsigned k, h;
            wr = we && (int'(wsel) == c);
            k  = wr ? k_in : m_ksh[c];
            h  = wr ? h_in : m_hsh[c];
            md = wr ? mode_in : m_msh[c];
            m_done[c] = 0;
            if (m_run[c]) begin
                if (!st[c]) begin
                    m_run[c] = 0; m_left[c] = 0; m_yp[c] = 0;
                end else if (m_left[c] > 1) begin
                    m_left[c]--; m_yp[c] = 0;
                end else if (m_mode[c]) begin
                    m_run[c] = 0; m_left[c] = 0; m_yp[c] = 0; m_done[c] = 1;
                end else if (k == 0) begin
                    m_run[c] = 0; m_left[c] = 0; m_yp[c] = 0;
                end else m_load(c, k, h, md);
            end else if (st[c] && !m_stp[c] && k != 0) begin
                m_load(c, k, h, md);
            end else begin
                m_left[c] = 0; m_yp[c] = 0;
            end
            if (wr) begin m_ksh[c] = k_in; m_hsh[c] = h_in; m_msh[c] = mode_in; end
            m_stp[c] = st[c];
        end
    endfunction

    task automatic check(input string tag);
        logic [CH*W-1:0] eq;
        logic [CH-1:0]   eyp, eyl, eb, ed;
        for (int c = 0; c < CH; c++) begin
            eq[c*W +: W] = m_left[c];
            eyp[c] = m_yp[c];
            // Level is high while fewer than h cycles of the period have elapsed.
            eyl[c] = m_run[c] && ((m_k[c] - m_left[c]) < m_h[c]);
            eb[c]  = m_run[c];
            ed[c]  = m_done[c];
        end
        vecs++; assert (q === eq) else begin errs++; $error("FAIL %s q got %h want %h", tag, q, eq); end
        vecs++; assert (yp === eyp) else begin errs++; $error("FAIL %s yp got %b want %b", tag, yp, eyp); end
        vecs++; assert (yl === eyl) else begin errs++; $error("FAIL %s yl got %b want %b", tag, yl, eyl); end
        vecs++; assert (busy === eb) else begin errs++; $error("FAIL %s busy got %b want %b", tag, busy, eb); end
        vecs++; assert (done === ed) else begin errs++; $error("FAIL %s done got %b want %b", tag, done, ed); end
    endtask

    task automatic expect_int(input string tag, input int got, input int want);
        vecs++;
        assert (got == want) else begin errs++; $error("FAIL %s got %0d want %0d", tag, got, want); end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        m_step();
        #1 check(tag);
    endtask

    task automatic wr_cfg(input int c, input int k, input int h, input bit md);
        we = 1'b1; wsel = CHW'(c); k_in = W'(k); h_in = W'(h); mode_in = md;
        tick("write");
        we = 1'b0;
    endtask

    initial begin
        int cnt_yp, cnt_dn, found;
        m_reset();
        #2 check("reset");
        @(posedge clk); #1 rstn = 1'b1;

        // Periodic ch0 k=5 h=2: yp on ticks 1,6,11,16.
        wr_cfg(0, 5, 2, 0);
        st[0] = 1'b1;
        cnt_yp = 0;
        for (int i = 1; i <= 20; i++) begin
            tick("periodic");
            if (yp[0]) cnt_yp++;
            if (i == 1) expect_int("periodic_first_q", int'(q[0 +: W]), 5);
        end
        expect_int("periodic_yp_count", cnt_yp, 4);

        // One-shot ch1 k=4, held start then restart.
        wr_cfg(1, 4, 1, 1);
        st[1] = 1'b1;
        cnt_yp = 0; cnt_dn = 0;
        for (int i = 0; i < 12; i++) begin
            tick("oneshot");
            if (yp[1]) cnt_yp++;
            if (done[1]) begin cnt_dn++; expect_int("oneshot_done_at", i, 4); end
        end
        expect_int("oneshot_yp_count", cnt_yp, 1);
        expect_int("oneshot_done_count", cnt_dn, 1);
        st[1] = 1'b0; tick("oneshot_drop");
        st[1] = 1'b1;
        for (int i = 0; i < 6; i++) tick("oneshot_restart");

        // Abort ch0 at q==3 after reconfig to k=8, then k=0 start is ignored.
        wr_cfg(0, 8, 3, 0);
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            tick("abort_wait");
            if (int'(q[0 +: W]) == 3 && m_k[0] == 8) found = 1;
        end
        expect_int("abort_reached_q3", found, 1);
        st[0] = 1'b0; tick("abort");
        expect_int("abort_busy", int'(busy[0]), 0);
        wr_cfg(0, 0, 0, 0);
        st[0] = 1'b1;
        for (int i = 0; i < 3; i++) tick("zero_k");
        expect_int("zero_k_busy", int'(busy[0]), 0);

        // Mid-period reconfig of ch2.
        wr_cfg(2, 6, 2, 0);
        st[2] = 1'b1;
        tick("reconf"); tick("reconf");
        wr_cfg(2, 3, 1, 0);
        for (int i = 0; i < 15; i++) tick("reconf");

        // Async reset mid-count on ch0/ch3.
        st = '0; tick("pre_rst");
        wr_cfg(0, 3, 1, 0); wr_cfg(3, 7, 3, 0);
        st[0] = 1'b1; st[3] = 1'b1;
        for (int i = 0; i < 5; i++) tick("pre_rst_run");
        #3 rstn = 1'b0;
        m_reset();
        #1 check("async_rst");
        @(posedge clk); #1 rstn = 1'b1;
        check("rst_release");
        wr_cfg(0, 3, 1, 0); wr_cfg(3, 7, 3, 0);
        st = '0; tick("indep_drop");
        st[0] = 1'b1; st[3] = 1'b1;
        for (int i = 0; i < 25; i++) tick("indep");

        // Write-through on ch1 start edge.
        st = '0; tick("wt_drop");
        we = 1'b1; wsel = 2'd1; k_in = 2; h_in = 1; mode_in = 1'b0; st[1] = 1'b1;
        tick("write_through");
        we = 1'b0;
        expect_int("write_through_q", int'(q[1*W +: W]), 2);
        for (int i = 0; i < 6; i++) tick("wt_run");

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            we      = ($urandom_range(0, 3) == 0);
            wsel    = CHW'($urandom_range(0, CH - 1));
            k_in    = W'($urandom_range(0, 6));
            h_in    = W'($urandom_range(0, 7));
            mode_in = ($urandom_range(0, 3) == 0);
            for (int c = 0; c < CH; c++)
                if ($urandom_range(0, 7) == 0) st[c] = ~st[c];
            tick("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
